// File: rtl/clb_cfg_pkg.sv
// Shared configuration-chain definitions: FSM state encoding and frame/counter
// width derivations used by LUT loaders, routing muxes and switch boxes.
package clb_cfg_pkg;

    localparam int DEF_LUT_INPUTS = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } cfg_state_e;

    function automatic int cfg_width(input int lut_inputs);
        return 2 ** lut_inputs;
    endfunction

    function automatic int cnt_width(input int cfg_w);
        return $clog2(cfg_w + 1);
    endfunction

    localparam int DEF_CFG_W = cfg_width(DEF_LUT_INPUTS);
    localparam int DEF_CNT_W = cnt_width(DEF_CFG_W);

endpackage

// File: rtl/cfg_shift_reg.sv
// Shadow shift register for the config scan path: serial in at the LSB,
// shifts only while enabled, MSB tapped for the daisy chain.
module cfg_shift_reg #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         din,
    output logic [W-1:0] q,
    output logic         msb
);

    logic [W-1:0] shadow_r;
    logic [W-1:0] shadow_nxt_s;

    generate
        if (W == 1) begin : g_single
            assign shadow_nxt_s = din;
        end else begin : g_multi
            assign shadow_nxt_s = {shadow_r[W-2:0], din};
        end
    endgenerate

    // Shadow register: loads the shifted value while enabled, otherwise holds
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shadow_r <= '0;
        end else if (en) begin
            shadow_r <= shadow_nxt_s;
        end else begin
            shadow_r <= shadow_r;
        end
    end

    assign q   = shadow_r;
    assign msb = shadow_r[W-1];

endmodule

// File: rtl/lut_config_loader.sv
// Double-buffered serial loader feeding the CLB LUT select mux: frames fill a
// shadow register and are committed to the active table in one edge.
module lut_config_loader
    import clb_cfg_pkg::*;
#(
    parameter  int LUT_INPUTS = DEF_LUT_INPUTS,
    localparam int CFG_W      = cfg_width(LUT_INPUTS),
    localparam int CNT_W      = cnt_width(CFG_W)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_en,
    input  logic             cfg_in,
    output logic             cfg_out,
    output logic [CFG_W-1:0] lut_data,
    output logic             lut_valid,
    output logic             cfg_done,
    output logic             cfg_err
);

    localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CFG_W - 1);
    // A one-bit frame is complete as soon as its first bit is accepted
    localparam cfg_state_e       START_ST  = (CFG_W == 1) ? COMMIT : SHIFT;
    localparam logic [CNT_W-1:0] START_CNT = (CFG_W == 1) ? CNT_ZERO : CNT_ONE;

    cfg_state_e       state_r, state_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic [CFG_W-1:0] shadow_s;
    logic [CFG_W-1:0] active_r;
    logic             valid_r, done_r, err_r;
    logic             commit_s, abort_s;
    logic             tap_s;

    cfg_shift_reg #(.W(CFG_W)) u_shadow (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (cfg_en),
        .din   (cfg_in),
        .q     (shadow_s),
        .msb   (tap_s)
    );

    // Next-state, bit counter and commit/abort strobes
    always_comb begin
        state_s  = state_r;
        cnt_s    = cnt_r;
        commit_s = 1'b0;
        abort_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (cfg_en) begin
                    state_s = START_ST;
                    cnt_s   = START_CNT;
                end else begin
                    state_s = IDLE;
                    cnt_s   = CNT_ZERO;
                end
            end
            SHIFT: begin
                if (cfg_en) begin
                    if (cnt_r == CNT_LAST) begin
                        state_s = COMMIT;
                        cnt_s   = CNT_ZERO;
                    end else begin
                        state_s = SHIFT;
                        cnt_s   = cnt_r + CNT_ONE;
                    end
                end else begin
                    state_s = IDLE;
                    cnt_s   = CNT_ZERO;
                    abort_s = 1'b1;
                end
            end
            COMMIT: begin
                commit_s = 1'b1;
                if (cfg_en) begin
                    state_s = START_ST;
                    cnt_s   = START_CNT;
                end else begin
                    state_s = IDLE;
                    cnt_s   = CNT_ZERO;
                end
            end
            default: begin
                state_s = IDLE;
                cnt_s   = CNT_ZERO;
            end
        endcase
    end

    // State, counter, active table and status pulses
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r  <= IDLE;
            cnt_r    <= CNT_ZERO;
            active_r <= '0;
            valid_r  <= 1'b0;
            done_r   <= 1'b0;
            err_r    <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            done_r  <= commit_s;
            err_r   <= abort_s;
            if (commit_s) begin
                active_r <= shadow_s;
                valid_r  <= 1'b1;
            end else begin
                active_r <= active_r;
                valid_r  <= valid_r;
            end
        end
    end

    assign cfg_out   = tap_s;
    assign lut_data  = active_r;
    assign lut_valid = valid_r;
    assign cfg_done  = done_r;
    assign cfg_err   = err_r;

endmodule

// File: tb/tb_lut_config_loader.sv
// Self-checking bench for lut_config_loader (CFG_W=4): per-scenario tasks plus
// a scoreboard of expected frames checked whenever cfg_done pulses.
module tb_lut_config_loader;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cfg_en = 1'b0;
    logic       cfg_in = 1'b0;
    logic       cfg_out;
    logic [3:0] lut_data;
    logic       lut_valid;
    logic       cfg_done;
    logic       cfg_err;

    int         tests = 0;
    int         fails = 0;
    logic [3:0] sb[$];
    logic [3:0] m_shadow = 4'b0000;
    int         m_cnt = 0;

    lut_config_loader #(.LUT_INPUTS(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_en    (cfg_en),
        .cfg_in    (cfg_in),
        .cfg_out   (cfg_out),
        .lut_data  (lut_data),
        .lut_valid (lut_valid),
        .cfg_done  (cfg_done),
        .cfg_err   (cfg_err)
    );

    always #5 clk = ~clk;

    // Scoreboard: every committed frame must match the oldest expected frame
    always @(negedge clk) begin
        if (cfg_done === 1'b1) begin
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL sb_unexpected_done: got lut_data=%b, required no cfg_done", lut_data);
            end else begin
                logic [3:0] e;
                e = sb.pop_front();
                if (lut_data !== e) begin
                    fails++;
                    $display("FAIL sb_frame: got lut_data=%b, required %b", lut_data, e);
                end
            end
        end
    end

    // One clock: drive inputs, update the bench frame model, settle 1 time unit past the edge
    task automatic step(input logic en, input logic b);
        cfg_en = en;
        cfg_in = b;
        @(posedge clk);
        if (!rst_n) begin
            m_shadow = 4'b0000;
            m_cnt    = 0;
        end else if (en) begin
            m_shadow = {m_shadow[2:0], b};
            m_cnt++;
            if (m_cnt == 4) begin
                sb.push_back(m_shadow);
                m_cnt = 0;
            end
        end else begin
            m_cnt = 0;
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        tests++; if (lut_data !== 4'b0000) begin fails++; $display("FAIL reset_lut_data: got %b, required 0000", lut_data); end
        tests++; if (lut_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b, required 0", lut_valid); end
        tests++; if (cfg_done !== 1'b0 || cfg_err !== 1'b0) begin fails++; $display("FAIL reset_pulses: got done=%b err=%b, required 0 0", cfg_done, cfg_err); end
        tests++; if (cfg_out !== 1'b0) begin fails++; $display("FAIL reset_cfg_out: got %b, required 0", cfg_out); end
        rst_n = 1'b1;
    endtask

    task automatic test_single_frame();
        logic [3:0] pat;
        pat = 4'b1011;
        for (int i = 0; i < 4; i++) step(1'b1, pat[3-i]);
        tests++; if (cfg_done !== 1'b0 || lut_valid !== 1'b0) begin fails++; $display("FAIL single_early: got done=%b valid=%b, required 0 0", cfg_done, lut_valid); end
        step(1'b0, 1'b0);
        tests++; if (cfg_done !== 1'b1) begin fails++; $display("FAIL single_done: got %b, required 1", cfg_done); end
        tests++; if (lut_data !== 4'b1011 || lut_valid !== 1'b1) begin fails++; $display("FAIL single_data: got %b valid=%b, required 1011 valid=1", lut_data, lut_valid); end
        step(1'b0, 1'b0);
        tests++; if (cfg_done !== 1'b0 || lut_valid !== 1'b1) begin fails++; $display("FAIL single_pulse_width: got done=%b valid=%b, required 0 1", cfg_done, lut_valid); end
    endtask

    task automatic test_abort();
        step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        step(1'b0, 1'b0);
        tests++; if (cfg_err !== 1'b1 || cfg_done !== 1'b0) begin fails++; $display("FAIL abort_err: got err=%b done=%b, required 1 0", cfg_err, cfg_done); end
        tests++; if (lut_data !== 4'b1011) begin fails++; $display("FAIL abort_data: got %b, required 1011", lut_data); end
        step(1'b0, 1'b0);
        tests++; if (cfg_err !== 1'b0 || cfg_done !== 1'b0) begin fails++; $display("FAIL abort_pulse_width: got err=%b done=%b, required 0 0", cfg_err, cfg_done); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] pat;
        int         done_at[$];
        logic [3:0] data_at[$];
        logic       err_seen;
        pat = 8'b1011_0110;
        err_seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step(i < 8, (i < 8) ? pat[7-i] : 1'b0);
            if (cfg_done === 1'b1) begin
                done_at.push_back(i);
                data_at.push_back(lut_data);
            end
            if (cfg_err !== 1'b0) err_seen = 1'b1;
        end
        tests++;
        if (done_at.size() != 2) begin
            fails++; $display("FAIL b2b_count: got %0d done pulses, required 2", done_at.size());
        end else begin
            tests++; if (done_at[0] != 4 || done_at[1] != 8) begin fails++; $display("FAIL b2b_spacing: got steps %0d,%0d, required 4,8", done_at[0], done_at[1]); end
            tests++; if (data_at[0] !== 4'b1011 || data_at[1] !== 4'b0110) begin fails++; $display("FAIL b2b_data: got %b,%b, required 1011,0110", data_at[0], data_at[1]); end
        end
        tests++; if (err_seen) begin fails++; $display("FAIL b2b_err: got cfg_err high, required low"); end
    endtask

    task automatic test_daisy();
        logic [7:0] pat;
        pat = 8'b1011_0000;
        for (int i = 0; i < 8; i++) begin
            step(1'b1, pat[7-i]);
            if (i >= 3) begin
                tests++;
                if (cfg_out !== pat[10-i]) begin fails++; $display("FAIL daisy_out_%0d: got %b, required %b", i + 1, cfg_out, pat[10-i]); end
            end
        end
        step(1'b0, 1'b0);
        tests++; if (lut_data !== 4'b0000) begin fails++; $display("FAIL daisy_commit: got %b, required 0000", lut_data); end
    endtask

    task automatic test_reset_mid();
        logic [3:0] pat;
        pat = 4'b1011;
        for (int i = 0; i < 4; i++) step(1'b1, pat[3-i]);
        step(1'b0, 1'b0);
        tests++; if (lut_data !== 4'b1011) begin fails++; $display("FAIL rmid_preload: got %b, required 1011", lut_data); end
        for (int i = 0; i < 3; i++) step(1'b1, pat[3-i]);
        rst_n = 1'b0;
        step(1'b1, 1'b1);
        tests++; if (lut_data !== 4'b0000 || lut_valid !== 1'b0) begin fails++; $display("FAIL rmid_clear: got %b valid=%b, required 0000 valid=0", lut_data, lut_valid); end
        tests++; if (cfg_done !== 1'b0 || cfg_err !== 1'b0 || cfg_out !== 1'b0) begin fails++; $display("FAIL rmid_outputs: got done=%b err=%b out=%b, required 0 0 0", cfg_done, cfg_err, cfg_out); end
        rst_n = 1'b1;
        step(1'b0, 1'b0);
        tests++; if (cfg_done !== 1'b0 || cfg_err !== 1'b0) begin fails++; $display("FAIL rmid_no_pulse: got done=%b err=%b, required 0 0", cfg_done, cfg_err); end
        pat = 4'b0101;
        for (int i = 0; i < 4; i++) step(1'b1, pat[3-i]);
        step(1'b0, 1'b0);
        tests++; if (cfg_done !== 1'b1 || lut_data !== 4'b0101 || lut_valid !== 1'b1) begin fails++; $display("FAIL rmid_reload: got done=%b data=%b valid=%b, required 1 0101 1", cfg_done, lut_data, lut_valid); end
    endtask

    task automatic test_idle_gaps();
        logic held;
        step(1'b1, 1'b1);
        held = cfg_out;
        tests++; if (cfg_out !== m_shadow[3]) begin fails++; $display("FAIL gap_model_out: got %b, required %b", cfg_out, m_shadow[3]); end
        step(1'b0, 1'b0);
        tests++; if (cfg_err !== 1'b1 || cfg_done !== 1'b0) begin fails++; $display("FAIL gap_err: got err=%b done=%b, required 1 0", cfg_err, cfg_done); end
        tests++; if (cfg_out !== held) begin fails++; $display("FAIL gap_hold1: got %b, required %b", cfg_out, held); end
        step(1'b0, 1'b1);
        tests++; if (cfg_out !== held || cfg_err !== 1'b0) begin fails++; $display("FAIL gap_hold2: got out=%b err=%b, required %b 0", cfg_out, cfg_err, held); end
        step(1'b1, 1'b0);
        held = cfg_out;
        step(1'b0, 1'b1);
        tests++; if (cfg_out !== held || cfg_err !== 1'b1) begin fails++; $display("FAIL gap_hold3: got out=%b err=%b, required %b 1", cfg_out, cfg_err, held); end
        step(1'b0, 1'b0);
        tests++; if (lut_data !== 4'b0101 || cfg_done !== 1'b0) begin fails++; $display("FAIL gap_data: got %b done=%b, required 0101 0", lut_data, cfg_done); end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_abort();
        test_back_to_back();
        test_daisy();
        test_reset_mid();
        test_idle_gaps();
        step(1'b0, 1'b0);
        tests++;
        if (sb.size() != 0) begin fails++; $display("FAIL sb_leftover: got %0d uncommitted frames, required 0", sb.size()); end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
